// File: rtl/imem_load_ctrl_if.sv
// Handshake and memory-write bundle between the file streamer/host (master)
// and the instruction-memory load controller (slave).
interface imem_load_ctrl_if #(
  parameter int unsigned AW = 5
);
  logic          Start;
  logic          Word_valid;
  logic [31:0]   Word_in;
  logic          End_file;
  logic          Word_ready;
  logic          Imem_wr;
  logic [AW-1:0] Imem_addr;
  logic [31:0]   Imem_wdata;
  logic          Cpu_rst_n;
  logic          Busy;
  logic          Done;
  logic          Overflow;
  logic [AW:0]   Word_count;

  modport master (
    output Start, Word_valid, Word_in, End_file,
    input  Word_ready, Imem_wr, Imem_addr, Imem_wdata, Cpu_rst_n, Busy, Done, Overflow,
           Word_count
  );

  modport slave (
    input  Start, Word_valid, Word_in, End_file,
    output Word_ready, Imem_wr, Imem_addr, Imem_wdata, Cpu_rst_n, Busy, Done, Overflow,
           Word_count
  );
endinterface

// File: rtl/imem_load_ctrl.sv
// Streams a program into instruction memory, pads the tail with NOPs and then
// releases the processor reset after a fixed delay. All outputs are registered.
module imem_load_ctrl #(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned REL_DLY = 4
) (
  input logic           Clk,
  input logic           Rst,
  imem_load_ctrl_if.slave bus
);

  localparam logic [31:0] Nop     = 32'h0000_0013;
  localparam logic [AW:0] DepthW  = (AW+1)'(DEPTH);
  localparam logic [7:0]  RelLast = 8'(REL_DLY - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StPad,
    StWait,
    StRun,
    StError
  } state_e;

  state_e        state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   pad_ptr_q, pad_ptr_d;
  logic [7:0]    wait_q, wait_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          ready_q, ready_d;
  logic          cpu_rst_n_q, cpu_rst_n_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic          accept;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pad_ptr_d = pad_ptr_q;
    wait_d    = wait_q;
    wr_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ovf_d     = ovf_q;
    accept    = bus.Word_valid & ready_q;

    unique case (state_q)
      StIdle: begin
        if (bus.Start) begin
          state_d = StLoad;
          count_d = '0;
          wait_d  = '0;
        end
      end
      StLoad: begin
        // A word offered once the memory is full is dropped, even with End_file.
        if (bus.Word_valid && (count_q == DepthW)) begin
          ovf_d   = 1'b1;
          state_d = StError;
        end else begin
          if (accept) begin
            wr_d    = 1'b1;
            addr_d  = count_q[AW-1:0];
            wdata_d = bus.Word_in;
            count_d = count_q + 1'b1;
          end
          if (bus.End_file) begin
            state_d   = StPad;
            pad_ptr_d = count_d;
          end
        end
      end
      StPad: begin
        if (pad_ptr_q < DepthW) begin
          wr_d      = 1'b1;
          addr_d    = pad_ptr_q[AW-1:0];
          wdata_d   = Nop;
          pad_ptr_d = pad_ptr_q + 1'b1;
        end
        if (pad_ptr_q >= (DepthW - 1'b1)) begin
          state_d = StWait;
          wait_d  = '0;
        end
      end
      StWait: begin
        if (wait_q == RelLast) begin
          state_d = StRun;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StRun: begin
        if (bus.Start) begin
          state_d = StLoad;
          count_d = '0;
          wait_d  = '0;
        end
      end
      StError: begin
        if (bus.Start) begin
          state_d = StLoad;
          count_d = '0;
          wait_d  = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Status outputs are decoded from the next state so they line up with it.
    ready_d     = (state_d == StLoad) && (count_d < DepthW);
    busy_d      = state_d inside {StLoad, StPad, StWait};
    done_d      = (state_d == StRun);
    cpu_rst_n_d = (state_d == StRun);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= StIdle;
      count_q     <= '0;
      pad_ptr_q   <= '0;
      wait_q      <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ready_q     <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      pad_ptr_q   <= pad_ptr_d;
      wait_q      <= wait_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ready_q     <= ready_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.Word_ready = ready_q;
  assign bus.Imem_wr    = wr_q;
  assign bus.Imem_addr  = addr_q;
  assign bus.Imem_wdata = wdata_q;
  assign bus.Cpu_rst_n  = cpu_rst_n_q;
  assign bus.Busy       = busy_q;
  assign bus.Done       = done_q;
  assign bus.Overflow   = ovf_q;
  assign bus.Word_count = count_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl: normal load, empty load, full load,
// overflow, reload from RUN and asynchronous reset mid-pad.
module tb_imem_load_ctrl;

  localparam int unsigned DEPTH   = 32;
  localparam int unsigned AW      = 5;
  localparam int unsigned REL_DLY = 4;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic Clk = 1'b0;
  logic Rst = 1'b0;

  imem_load_ctrl_if #(.AW(AW)) bus ();

  imem_load_ctrl #(
    .DEPTH  (DEPTH),
    .AW     (AW),
    .REL_DLY(REL_DLY)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus.slave)
  );

  always #5 Clk = ~Clk;

  logic [31:0] mem [DEPTH];
  int          wr_cnt   = 0;
  int          n_checks = 0;
  int          n_fail   = 0;

  // Memory model fed from the write strobe, sampled mid-cycle.
  always @(negedge Clk) begin
    if (Rst && bus.Imem_wr) begin
      mem[bus.Imem_addr] <= bus.Imem_wdata;
      wr_cnt             <= wr_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_in();
    bus.Start      = 1'b0;
    bus.Word_valid = 1'b0;
    bus.Word_in    = '0;
    bus.End_file   = 1'b0;
  endtask

  task automatic do_reset();
    Rst = 1'b0;
    idle_in();
    repeat (2) cyc();
    Rst = 1'b1;
    cyc();
  endtask

  task automatic pulse_start();
    bus.Start = 1'b1;
    cyc();
    bus.Start = 1'b0;
  endtask

  task automatic send_words(input logic [31:0] base, input int n, input bit eof_last,
                            input bit chk);
    for (int i = 0; i < n; i++) begin
      bus.Word_valid = 1'b1;
      bus.Word_in    = base + 32'(i);
      bus.End_file   = eof_last && (i == n - 1);
      cyc();
      if (chk) begin
        check_eq($sformatf("wr_word%0d", i), {bus.Imem_wr, bus.Imem_addr, bus.Imem_wdata},
                 {1'b1, AW'(i), base + 32'(i)});
      end
    end
    bus.Word_valid = 1'b0;
    bus.End_file   = 1'b0;
  endtask

  task automatic wait_wr_addr(input logic [AW-1:0] a);
    int n = 0;
    while (!(bus.Imem_wr && bus.Imem_addr == a) && n < 200) begin
      cyc();
      n++;
    end
    check_eq($sformatf("wait_wr_addr%0d", a), 64'(n < 200), 64'd1);
  endtask

  task automatic wait_rise(output int n);
    n = 0;
    while (!bus.Cpu_rst_n && n < 200) begin
      cyc();
      n++;
    end
  endtask

  function automatic int count_bad(input logic [31:0] base, input int nwords);
    int bad = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      logic [31:0] e;
      e = (i < nwords) ? base + 32'(i) : NOP;
      if (mem[i] !== e) bad++;
    end
    return bad;
  endfunction

  function automatic logic [48:0] outs_vec();
    return {bus.Cpu_rst_n, bus.Imem_wr, bus.Imem_addr, bus.Imem_wdata, bus.Word_ready,
            bus.Busy, bus.Done, bus.Overflow, bus.Word_count};
  endfunction

  initial begin
    int n;
    int w0;

    // Reset values and Word_valid ignored in IDLE.
    Rst = 1'b0;
    idle_in();
    repeat (2) cyc();
    check_eq("reset_outs", 64'(outs_vec()), 64'd0);
    Rst = 1'b1;
    cyc();
    bus.Word_valid = 1'b1;
    cyc();
    bus.Word_valid = 1'b0;
    check_eq("idle_ignore", {bus.Imem_wr, bus.Word_ready, bus.Busy, bus.Word_count}, 64'd0);

    // Three words, End_file on the last.
    pulse_start();
    check_eq("a_load", {bus.Busy, bus.Word_ready, bus.Cpu_rst_n, bus.Done, bus.Word_count},
             {1'b1, 1'b1, 1'b0, 1'b0, 6'd0});
    w0 = wr_cnt;
    send_words(32'hAAAA_0001, 3, 1'b1, 1'b1);
    wait_wr_addr(5'd31);
    wait_rise(n);
    check_eq("a_rel_dly", 64'(n), 64'(REL_DLY));
    check_eq("a_wr_cnt", 64'(wr_cnt - w0), 64'd32);
    check_eq("a_mem", 64'(count_bad(32'hAAAA_0001, 3)), 64'd0);
    check_eq("a_status", {bus.Word_count, bus.Done, bus.Busy, bus.Cpu_rst_n},
             {6'd3, 1'b1, 1'b0, 1'b1});

    // Empty program.
    do_reset();
    pulse_start();
    w0 = wr_cnt;
    bus.End_file = 1'b1;
    cyc();
    bus.End_file = 1'b0;
    wait_rise(n);
    check_eq("b_timeout", 64'(n < 200), 64'd1);
    check_eq("b_wr_cnt", 64'(wr_cnt - w0), 64'd32);
    check_eq("b_mem", 64'(count_bad(32'h0, 0)), 64'd0);
    check_eq("b_status", {bus.Word_count, bus.Done, bus.Cpu_rst_n}, {6'd0, 1'b1, 1'b1});

    // Full program, End_file on word 32: one-cycle PAD then WAIT.
    do_reset();
    pulse_start();
    w0 = wr_cnt;
    send_words(32'hCCCC_0000, 32, 1'b1, 1'b0);
    check_eq("d_ready", 64'(bus.Word_ready), 64'd0);
    wait_rise(n);
    check_eq("d_pad_len", 64'(n), 64'(REL_DLY + 1));
    check_eq("d_wr_cnt", 64'(wr_cnt - w0), 64'd32);
    check_eq("d_mem", 64'(count_bad(32'hCCCC_0000, 32)), 64'd0);
    check_eq("d_count", 64'(bus.Word_count), 64'd32);

    // Restart from RUN and reload two words.
    pulse_start();
    check_eq("r_restart", {bus.Cpu_rst_n, bus.Done, bus.Busy, bus.Word_count},
             {1'b0, 1'b0, 1'b1, 6'd0});
    w0 = wr_cnt;
    send_words(32'hBBBB_0001, 2, 1'b1, 1'b1);
    wait_rise(n);
    check_eq("r_timeout", 64'(n < 200), 64'd1);
    check_eq("r_wr_cnt", 64'(wr_cnt - w0), 64'd32);
    check_eq("r_mem", 64'(count_bad(32'hBBBB_0001, 2)), 64'd0);

    // Overflow without End_file.
    do_reset();
    pulse_start();
    w0 = wr_cnt;
    send_words(32'hDDDD_0000, 32, 1'b0, 1'b0);
    check_eq("c_full", {bus.Word_count, bus.Word_ready, bus.Overflow}, {6'd32, 1'b0, 1'b0});
    bus.Word_valid = 1'b1;
    bus.Word_in    = 32'hEEEE_EEEE;
    cyc();
    check_eq("c_ovf", {bus.Overflow, bus.Busy, bus.Done, bus.Cpu_rst_n, bus.Imem_wr},
             {1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    repeat (3) cyc();
    bus.Word_valid = 1'b0;
    check_eq("c_err_hold", {bus.Overflow, bus.Cpu_rst_n, bus.Word_ready, bus.Busy},
             {1'b1, 1'b0, 1'b0, 1'b0});
    check_eq("c_no33", 64'(wr_cnt - w0), 64'd32);
    pulse_start();
    check_eq("c_restart", {bus.Overflow, bus.Busy, bus.Word_ready, bus.Word_count},
             {1'b0, 1'b1, 1'b1, 6'd0});

    // Overflowing word arriving together with End_file.
    w0 = wr_cnt;
    send_words(32'h1000_0000, 32, 1'b0, 1'b0);
    bus.Word_valid = 1'b1;
    bus.End_file   = 1'b1;
    cyc();
    bus.Word_valid = 1'b0;
    bus.End_file   = 1'b0;
    check_eq("c_ovf_eof", {bus.Overflow, bus.Busy, bus.Imem_wr}, {1'b1, 1'b0, 1'b0});
    check_eq("c_ovf_eof_wr", 64'(wr_cnt - w0), 64'd32);

    // Asynchronous reset mid-pad.
    do_reset();
    pulse_start();
    bus.End_file = 1'b1;
    cyc();
    bus.End_file = 1'b0;
    wait_wr_addr(5'd10);
    #2;
    Rst = 1'b0;
    #1;
    check_eq("e_async_rst", 64'(outs_vec()), 64'd0);
    w0 = wr_cnt;
    repeat (4) cyc();
    check_eq("e_no_wr", 64'(wr_cnt - w0), 64'd0);
    Rst = 1'b1;
    repeat (3) cyc();
    check_eq("e_idle_after", {bus.Busy, bus.Done, bus.Cpu_rst_n, bus.Imem_wr, bus.Word_count},
             64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_load_ctrl.md
IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 32, meaning the number of instruction memory words.
REQ-002 The block SHALL have parameter AW, default 5, meaning the instruction memory address width; DEPTH = 2^AW.
REQ-003 The block SHALL have parameter REL_DLY, default 4, meaning the number of cycles between load completion and processor reset release; legal range is 1..255.
REQ-004 The block SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port Rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port Start, input, 1 bit: a one-cycle request to begin or restart a program load.
REQ-007 The block SHALL have port Word_valid, input, 1 bit: Word_in carries a valid instruction from the file streamer.
REQ-008 The block SHALL have port Word_in, input, 32 bits: the instruction word.
REQ-009 The block SHALL have port End_file, input, 1 bit: the file streamer has no more words; may coincide with the last Word_valid.
REQ-010 The block SHALL have port Word_ready, output, 1 bit: the block accepts Word_in this cycle.
REQ-011 The block SHALL have port Imem_wr, output, 1 bit: instruction memory write strobe.
REQ-012 The block SHALL have port Imem_addr, output, AW bits: instruction memory word address.
REQ-013 The block SHALL have port Imem_wdata, output, 32 bits: instruction memory write data.
REQ-014 The block SHALL have port Cpu_rst_n, output, 1 bit: processor reset, active-low; low holds the processor in reset.
REQ-015 The block SHALL have port Busy, output, 1 bit: high in LOAD, PAD and WAIT.
REQ-016 The block SHALL have port Done, output, 1 bit: high in RUN.
REQ-017 The block SHALL have port Overflow, output, 1 bit: sticky error flag for a program longer than DEPTH words.
REQ-018 The block SHALL have port Word_count, output, AW+1 bits: the number of program words accepted (pad words excluded).

Function
REQ-019 The block SHALL implement FSM states IDLE, LOAD, PAD, WAIT, RUN and ERROR, with all outputs registered.
REQ-020 IDLE SHALL go to LOAD on Start, clearing Word_count and the wait counter, with Cpu_rst_n held 0.
REQ-021 Word_ready SHALL be 1 only in LOAD with Word_count < DEPTH.
REQ-022 An accepted word (Word_valid & Word_ready) SHALL produce, on the next cycle, Imem_wr=1, Imem_addr=Word_count[AW-1:0] (pre-increment), Imem_wdata=Word_in, with Word_count incremented; the latency is 1 cycle.
REQ-023 Imem_wr SHALL be 0 in every cycle without a scheduled write; Imem_addr and Imem_wdata SHALL hold their last values.
REQ-024 End_file in LOAD, with or without a simultaneous accepted word, SHALL cause the word (if present) to be written and the FSM to go to PAD.
REQ-025 Word_valid in LOAD with Word_count == DEPTH and End_file low SHALL set Overflow and send the FSM to ERROR with no write.
REQ-026 A word arriving at Word_count == DEPTH together with End_file SHALL be dropped and Overflow set, with the FSM going to ERROR.
REQ-027 PAD SHALL write NOP 0x00000013 to each address from Word_count to DEPTH-1, one per cycle, then go to WAIT; if Word_count == DEPTH, PAD SHALL last 1 cycle with no write.
REQ-028 WAIT SHALL count REL_DLY cycles, then go to RUN.
REQ-029 In RUN, Cpu_rst_n and Done SHALL be 1 and Busy SHALL be 0.
REQ-030 Start in RUN SHALL cause Cpu_rst_n=0 and Done=0 on the next cycle, with the FSM going to LOAD and Word_count cleared.
REQ-031 Start in LOAD, PAD or WAIT SHALL be ignored.
REQ-032 In ERROR, Cpu_rst_n SHALL stay 0 and Busy and Done SHALL be 0.
REQ-033 Only Start in ERROR SHALL clear Overflow, with the FSM going to LOAD.
REQ-034 Word_valid in IDLE, PAD, WAIT, RUN or ERROR SHALL be ignored, with Word_ready = 0.
REQ-035 An empty program (End_file in LOAD with no words) SHALL pad all DEPTH words with NOP, with Word_count = 0.

Reset
REQ-036 Rst=0 SHALL force, asynchronously, state IDLE, Cpu_rst_n=0, Imem_wr=0, Imem_addr=0, Imem_wdata=0, Word_ready=0, Busy=0, Done=0, Overflow=0, Word_count=0 and the wait counter to 0.
REQ-037 Rst deassertion SHALL be taken synchronously, with the first state change on the following Clk edge.
REQ-038 Rst asserted mid-LOAD or mid-PAD SHALL abandon the load; the partial memory contents SHALL not be relied upon, and a new Start is required.

Verification
REQ-039 The bench SHALL check: Start, 3 words 0xAAAA0001..0xAAAA0003 with End_file on the 3rd -> writes to addresses 0..2, NOP to 3..31, Word_count=3, Cpu_rst_n rises exactly REL_DLY cycles after the PAD write to 31.
REQ-040 The bench SHALL check: Start, End_file with no words -> 32 NOP writes to 0..31, Word_count=0, then Done=1.
REQ-041 The bench SHALL check: 32 words, then a 33rd Word_valid without End_file -> no 33rd write, Overflow=1, state ERROR, Cpu_rst_n stays 0; Start -> Overflow=0, LOAD.
REQ-042 The bench SHALL check: 32 words with End_file on the 32nd -> no pad writes, 1-cycle PAD, then WAIT, then RUN.
REQ-043 The bench SHALL check: Start in RUN -> Cpu_rst_n=0 on the next cycle, and a reload of 2 words overwrites addresses 0..1 with pads from 2.
REQ-044 The bench SHALL check: Rst pulled low mid-PAD at address 10 -> all outputs take reset values immediately with no further Imem_wr.
